color_centroid_tracker: RTL and testbench

COLOR_CENTROID_TRACKER -- requirements
Module: color_centroid_tracker

---
 rtl/color_centroid_tracker.sv | 278 +++++++++++++++++++++++++++
 tb/tb_color_centroid_tracker.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_centroid_tracker.sv
// Colour-blob centroid tracker for a raster pixel stream.
// Each channel counts pixels whose selected colour component beats both
// other components by more than a per-channel margin, accumulates their
// coordinates, and at frame end divides the sums by the count with one
// shared bit-serial restoring divider.
module color_centroid_tracker #(
    parameter int                  NUM_CH    = 2,
    parameter int                  H_BITS    = 10,
    parameter int                  V_BITS    = 10,
    parameter logic [2*NUM_CH-1:0] CH_COLOR  = 4'b00_01,
    parameter int                  MIN_COUNT = 64
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic                       iDE,
    input  logic                       iVS,
    input  logic [7:0]                 iRed,
    input  logic [7:0]                 iGreen,
    input  logic [7:0]                 iBlue,
    input  logic [NUM_CH*8-1:0]        iTHR,
    input  logic                       iREADY,
    output logic                       oVALID,
    output logic [NUM_CH*H_BITS-1:0]   oX,
    output logic [NUM_CH*V_BITS-1:0]   oY,
    output logic [NUM_CH-1:0]          oFOUND,
    output logic                       oBUSY,
    output logic [7:0]                 oDROP_CNT
);

    localparam int CW  = H_BITS + V_BITS;          // count width
    localparam int SXW = H_BITS + CW;              // x-sum width
    localparam int SYW = V_BITS + CW;              // y-sum width
    localparam int QW  = (H_BITS > V_BITS) ? H_BITS : V_BITS;
    localparam int BW  = $clog2(QW + 1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, LATCH, DIV, DONE} state_t;
    state_t state_reg;

    // Raster front end
    logic               vs_prev_reg;
    logic               de_prev_reg;
    logic               frame_end;
    logic [H_BITS-1:0]  x_last_reg;
    logic [H_BITS-1:0]  x_now;
    logic [V_BITS-1:0]  y_reg;

    // Per-channel accumulators, staging copies and divider results
    logic [SXW-1:0]     acc_sx_reg  [NUM_CH];
    logic [SYW-1:0]     acc_sy_reg  [NUM_CH];
    logic [CW-1:0]      acc_cnt_reg [NUM_CH];
    logic [SXW-1:0]     stg_sx_reg  [NUM_CH];
    logic [SYW-1:0]     stg_sy_reg  [NUM_CH];
    logic [CW-1:0]      stg_cnt_reg [NUM_CH];
    logic [H_BITS-1:0]  res_x_reg   [NUM_CH];
    logic [V_BITS-1:0]  res_y_reg   [NUM_CH];

    // Shared divider
    logic [CHW-1:0]     ch_reg;
    logic               phase_y_reg;
    logic [BW-1:0]      bit_idx_reg;
    logic [CW-1:0]      div_rem_reg;
    logic [QW-1:0]      div_low_reg;
    logic [QW-1:0]      div_q_reg;
    logic [CW-1:0]      den;
    logic [CW-1:0]      up_ld;
    logic [QW-1:0]      low_ld;
    logic [CW-1:0]      rem_in;
    logic [QW-1:0]      low_in;
    logic [QW-1:0]      q_in;
    logic [CW:0]        rem2;
    logic               ge;
    logic [CW-1:0]      rem_nx;
    logic [QW-1:0]      low_nx;
    logic [QW-1:0]      q_nx;
    logic               div_last;

    logic [NUM_CH-1:0]        found_vec;
    logic [NUM_CH*H_BITS-1:0] x_final;
    logic [NUM_CH*V_BITS-1:0] y_final;

    // Frame end is the falling edge of the (active-low) vertical sync.
    assign frame_end = vs_prev_reg & ~iVS;
    // x restarts at the first valid pixel of a line, then saturates.
    assign x_now = !de_prev_reg ? '0 :
                   (x_last_reg == '1) ? x_last_reg : x_last_reg + 1'b1;

    // Edge history and raster coordinate tracking
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vs_prev_reg <= 1'b0;
            de_prev_reg <= 1'b0;
            x_last_reg  <= '0;
            y_reg       <= '0;
        end else begin
            vs_prev_reg <= iVS;
            de_prev_reg <= iDE;
            if (iDE)
                x_last_reg <= x_now;
            if (frame_end || state_reg == LATCH)
                y_reg <= '0;
            else if (de_prev_reg && !iDE && y_reg != '1)
                y_reg <= y_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [1:0] SEL = CH_COLOR[2*gi +: 2];
            logic [7:0]        comp_sel;
            logic [7:0]        comp_a;
            logic [7:0]        comp_b;
            logic signed [8:0] d_a;
            logic signed [8:0] d_b;
            logic signed [8:0] thr9;
            logic              match;

            // Route the dominant component and the two it must beat
            always_comb begin
                comp_sel = iBlue;
                comp_a   = iRed;
                comp_b   = iGreen;
                case (SEL)
                    2'd0: begin comp_sel = iRed;   comp_a = iGreen; comp_b = iBlue; end
                    2'd1: begin comp_sel = iGreen; comp_a = iRed;   comp_b = iBlue; end
                    default: begin comp_sel = iBlue; comp_a = iRed; comp_b = iGreen; end
                endcase
            end

            assign d_a   = $signed({1'b0, comp_sel}) - $signed({1'b0, comp_a});
            assign d_b   = $signed({1'b0, comp_sel}) - $signed({1'b0, comp_b});
            assign thr9  = $signed({1'b0, iTHR[8*gi +: 8]});
            // The detect-cycle pixel belongs to neither frame.
            assign match = iDE && !frame_end && (d_a > thr9) && (d_b > thr9);

            // Accumulate matches; snapshot in LATCH; discard on a dropped frame
            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    acc_sx_reg[gi]  <= '0;
                    acc_sy_reg[gi]  <= '0;
                    acc_cnt_reg[gi] <= '0;
                    stg_sx_reg[gi]  <= '0;
                    stg_sy_reg[gi]  <= '0;
                    stg_cnt_reg[gi] <= '0;
                end else begin
                    if (state_reg == LATCH) begin
                        stg_sx_reg[gi]  <= acc_sx_reg[gi];
                        stg_sy_reg[gi]  <= acc_sy_reg[gi];
                        stg_cnt_reg[gi] <= acc_cnt_reg[gi];
                    end
                    if (frame_end && state_reg != IDLE) begin
                        acc_sx_reg[gi]  <= '0;
                        acc_sy_reg[gi]  <= '0;
                        acc_cnt_reg[gi] <= '0;
                    end else if (state_reg == LATCH) begin
                        // Restart from this cycle's pixel, if any.
                        acc_sx_reg[gi]  <= match ? SXW'(x_now) : '0;
                        acc_sy_reg[gi]  <= match ? SYW'(y_reg) : '0;
                        acc_cnt_reg[gi] <= match ? CW'(1) : '0;
                    end else if (match) begin
                        acc_sx_reg[gi]  <= acc_sx_reg[gi] + SXW'(x_now);
                        acc_sy_reg[gi]  <= acc_sy_reg[gi] + SYW'(y_reg);
                        acc_cnt_reg[gi] <= acc_cnt_reg[gi] + 1'b1;
                    end
                end
            end

            // A zero count never reports found, whatever MIN_COUNT is.
            assign found_vec[gi] = (stg_cnt_reg[gi] >= CW'(MIN_COUNT)) && (stg_cnt_reg[gi] != '0);
            assign x_final[gi*H_BITS +: H_BITS] = found_vec[gi] ? res_x_reg[gi] : '0;

            // The last channel's y quotient finishes in the same cycle DONE is entered.
            if (gi == NUM_CH - 1) begin : g_last
                assign y_final[gi*V_BITS +: V_BITS] = found_vec[gi] ? q_nx[V_BITS-1:0] : '0;
            end else begin : g_mid
                assign y_final[gi*V_BITS +: V_BITS] = found_vec[gi] ? res_y_reg[gi] : '0;
            end
        end
    endgenerate

    // One restoring-divider step; the first step of each division loads
    // the upper dividend bits directly so every quotient costs exactly its width in cycles.
    always_comb begin
        den    = stg_cnt_reg[ch_reg];
        up_ld  = stg_sx_reg[ch_reg][SXW-1:H_BITS];
        low_ld = QW'(stg_sx_reg[ch_reg][H_BITS-1:0]) << (QW - H_BITS);
        if (phase_y_reg) begin
            up_ld  = stg_sy_reg[ch_reg][SYW-1:V_BITS];
            low_ld = QW'(stg_sy_reg[ch_reg][V_BITS-1:0]) << (QW - V_BITS);
        end
        rem_in   = (bit_idx_reg == '0) ? up_ld  : div_rem_reg;
        low_in   = (bit_idx_reg == '0) ? low_ld : div_low_reg;
        q_in     = (bit_idx_reg == '0) ? '0     : div_q_reg;
        rem2     = {rem_in, low_in[QW-1]};
        ge       = (rem2 >= {1'b0, den});
        rem_nx   = ge ? CW'(rem2 - {1'b0, den}) : CW'(rem2);
        low_nx   = low_in << 1;
        q_nx     = (q_in << 1) | QW'(ge);
        div_last = (bit_idx_reg == (phase_y_reg ? BW'(V_BITS - 1) : BW'(H_BITS - 1)));
    end

    // Control FSM, divider sequencing and registered result outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg   <= IDLE;
            ch_reg      <= '0;
            phase_y_reg <= 1'b0;
            bit_idx_reg <= '0;
            div_rem_reg <= '0;
            div_low_reg <= '0;
            div_q_reg   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                res_x_reg[c] <= '0;
                res_y_reg[c] <= '0;
            end
            oVALID    <= 1'b0;
            oBUSY     <= 1'b0;
            oX        <= '0;
            oY        <= '0;
            oFOUND    <= '0;
            oDROP_CNT <= '0;
        end else begin
            if (frame_end && state_reg != IDLE && oDROP_CNT != 8'hFF)
                oDROP_CNT <= oDROP_CNT + 1'b1;
            case (state_reg)
                IDLE: begin
                    if (frame_end) begin
                        state_reg <= LATCH;
                        oBUSY     <= 1'b1;
                    end
                end
                LATCH: begin
                    state_reg   <= DIV;
                    ch_reg      <= '0;
                    phase_y_reg <= 1'b0;
                    bit_idx_reg <= '0;
                end
                DIV: begin
                    div_rem_reg <= rem_nx;
                    div_low_reg <= low_nx;
                    div_q_reg   <= q_nx;
                    if (div_last) begin
                        bit_idx_reg <= '0;
                        if (!phase_y_reg) begin
                            res_x_reg[ch_reg] <= q_nx[H_BITS-1:0];
                            phase_y_reg       <= 1'b1;
                        end else begin
                            res_y_reg[ch_reg] <= q_nx[V_BITS-1:0];
                            phase_y_reg       <= 1'b0;
                            if (ch_reg == LAST_CH) begin
                                state_reg <= DONE;
                                oBUSY     <= 1'b0;
                                oVALID    <= 1'b1;
                                oX        <= x_final;
                                oY        <= y_final;
                                oFOUND    <= found_vec;
                            end else begin
                                ch_reg <= ch_reg + 1'b1;
                            end
                        end
                    end else begin
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (iREADY) begin
                        state_reg <= IDLE;
                        oVALID    <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Bench for color_centroid_tracker: directed and random frames checked
// against an integer reference model of the matching/centroid rules.
module tb_color_centroid_tracker;
    localparam int NUM_CH    = 2;
    localparam int H_BITS    = 10;
    localparam int V_BITS    = 10;
    localparam int MIN_COUNT = 64;
    localparam logic [3:0] CH_COLOR = 4'b00_01;
    // Result appears in cycle T+2+NUM_CH*(H_BITS+V_BITS).
    localparam int LAT = 2 + NUM_CH * (H_BITS + V_BITS);

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       de, vs, ready;
    logic [7:0]                 r, g, b;
    logic [NUM_CH*8-1:0]        thr_v;
    logic                       valid, busy;
    logic [NUM_CH*H_BITS-1:0]   ox;
    logic [NUM_CH*V_BITS-1:0]   oy;
    logic [NUM_CH-1:0]          found;
    logic [7:0]                 drop;

    always #5 clk = ~clk;

    color_centroid_tracker #(
        .NUM_CH(NUM_CH), .H_BITS(H_BITS), .V_BITS(V_BITS),
        .CH_COLOR(CH_COLOR), .MIN_COUNT(MIN_COUNT)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iDE(de), .iVS(vs),
        .iRed(r), .iGreen(g), .iBlue(b), .iTHR(thr_v), .iREADY(ready),
        .oVALID(valid), .oX(ox), .oY(oy), .oFOUND(found),
        .oBUSY(busy), .oDROP_CNT(drop)
    );

    int checks = 0;
    int errors = 0;
    int ch_code [NUM_CH];
    longint m_sx [NUM_CH];
    longint m_sy [NUM_CH];
    longint m_cnt [NUM_CH];
    int px, ly;
    logic [NUM_CH*H_BITS-1:0] exp_x, save_x;
    logic [NUM_CH*V_BITS-1:0] exp_y, save_y;
    logic [NUM_CH-1:0]        exp_f, save_f;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Channel matches when its component exceeds each other one by more than thr.
    function automatic bit match_ref(input int code, input int rv, input int gv, input int bv, input int t);
        int c [3];
        int s;
        c[0] = rv; c[1] = gv; c[2] = bv;
        s = c[code];
        return ((s - c[(code + 1) % 3]) > t) && ((s - c[(code + 2) % 3]) > t);
    endfunction

    task automatic pixel(input int rv, input int gv, input int bv);
        de = 1'b1; r = 8'(rv); g = 8'(gv); b = 8'(bv);
        for (int c = 0; c < NUM_CH; c++) begin
            if (match_ref(ch_code[c], rv, gv, bv, int'(thr_v[8*c +: 8]))) begin
                m_sx[c] += px; m_sy[c] += ly; m_cnt[c]++;
            end
        end
        px++;
        @(negedge clk);
    endtask

    task automatic end_line();
        de = 1'b0; ly++; px = 0;
        @(negedge clk);
    endtask

    task automatic start_frame();
        for (int c = 0; c < NUM_CH; c++) begin
            m_sx[c] = 0; m_sy[c] = 0; m_cnt[c] = 0;
        end
        ly = 0; px = 0; de = 1'b0; vs = 1'b1;
        @(negedge clk);
    endtask

    task automatic compute_expected();
        bit f;
        for (int c = 0; c < NUM_CH; c++) begin
            f = (m_cnt[c] >= MIN_COUNT) && (m_cnt[c] > 0);
            exp_f[c] = f;
            exp_x[c*H_BITS +: H_BITS] = f ? H_BITS'(m_sx[c] / m_cnt[c]) : '0;
            exp_y[c*V_BITS +: V_BITS] = f ? V_BITS'(m_sy[c] / m_cnt[c]) : '0;
        end
    endtask

    // Drives the vsync fall; returns at the negedge of cycle T+1.
    task automatic end_frame();
        de = 1'b0; vs = 1'b0;
        @(negedge clk);
    endtask

    // Cycle offset from T at which oVALID is first seen, -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int j = 2; j < 300; j++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                lat = j;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_found"}, 64'(found), 64'(exp_f));
        check({tag, "_x"}, 64'(ox), 64'(exp_x));
        check({tag, "_y"}, 64'(oy), 64'(exp_y));
    endtask

    task automatic finish_frame(input string tag);
        int lat;
        end_frame();
        check({tag, "_busy_t1"}, 64'(busy), 64'(1));
        wait_valid(lat);
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_busy_done"}, 64'(busy), 64'(0));
        check_result(tag);
        $display("frame %s: found=%b x=%0h y=%0h lat=%0d", tag, found, ox, oy, lat);
    endtask

    task automatic handshake();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("ack_valid_low", 64'(valid), 64'(0));
    endtask

    task automatic random_frame();
        int nl, len, pg, pr, k;
        thr_v = {8'($urandom_range(0, 60)), 8'($urandom_range(0, 60))};
        pg = $urandom_range(15, 60);
        pr = $urandom_range(15, 60);
        start_frame();
        nl = $urandom_range(8, 14);
        for (int l = 0; l < nl; l++) begin
            len = $urandom_range(8, 24);
            for (int p = 0; p < len; p++) begin
                k = $urandom_range(0, 99);
                if (k < pg)
                    pixel($urandom_range(0, 120), $urandom_range(100, 255), $urandom_range(0, 120));
                else if (k < pg + pr)
                    pixel($urandom_range(100, 255), $urandom_range(0, 120), $urandom_range(0, 120));
                else
                    pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            end
            end_line();
        end
        compute_expected();
    endtask

    initial begin
        int mr [3];
        bit mf [3];
        int cnt;
        mr[0] = 170; mr[1] = 159; mr[2] = 160;
        mf[0] = 1'b0; mf[1] = 1'b1; mf[2] = 1'b0;
        for (int c = 0; c < NUM_CH; c++) ch_code[c] = int'(CH_COLOR[2*c +: 2]);

        // Reset state
        rst_n = 1'b0; de = 1'b0; vs = 1'b0; ready = 1'b0;
        r = '0; g = '0; b = '0; thr_v = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_drop", 64'(drop), 64'(0));
        check("rst_found", 64'(found), 64'(0));
        check("rst_x", 64'(ox), 64'(0));
        check("rst_y", 64'(oy), 64'(0));
        rst_n = 1'b1;

        // Green 8x8 square at x=100..107, y=200..207
        thr_v = {8'd40, 8'd40};
        start_frame();
        for (int y = 0; y < 208; y++) begin
            if (y < 200) pixel(0, 0, 0);
            else for (int x = 0; x < 108; x++) begin
                if (x >= 100) pixel(0, 200, 0); else pixel(0, 0, 0);
            end
            end_line();
        end
        compute_expected();
        finish_frame("square");
        check("square_found_const", 64'(found), 64'(2'b01));
        check("square_x0_const", 64'(ox[H_BITS-1:0]), 64'(103));
        check("square_y0_const", 64'(oy[V_BITS-1:0]), 64'(203));
        handshake();

        // All-black frame
        start_frame();
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 16; x++) pixel(0, 0, 0);
            end_line();
        end
        compute_expected();
        finish_frame("black");
        check("black_found_const", 64'(found), 64'(0));
        handshake();

        // Count threshold: 63 vs 64 matches
        for (int n = 63; n <= 64; n++) begin
            start_frame();
            for (int x = 0; x < n; x++) pixel(0, 200, 0);
            end_line();
            compute_expected();
            finish_frame($sformatf("count%0d", n));
            check($sformatf("count%0d_found0", n), 64'(found[0]), 64'(n == 64));
            handshake();
        end

        // Margin: 63 sure matches plus one pixel at the margin boundary
        for (int t = 0; t < 3; t++) begin
            start_frame();
            for (int x = 0; x < 63; x++) pixel(0, 200, 0);
            end_line();
            pixel(mr[t], 200, 0);
            end_line();
            compute_expected();
            finish_frame($sformatf("margin_r%0d", mr[t]));
            check($sformatf("margin_r%0d_found0", mr[t]), 64'(found[0]), 64'(mf[t]));
            handshake();
        end

        // Random frames
        for (int f = 0; f < 6; f++) begin
            random_frame();
            finish_frame($sformatf("rand%0d", f));
            handshake();
        end

        // Result held across two dropped frames
        random_frame();
        finish_frame("hold");
        save_x = exp_x; save_y = exp_y; save_f = exp_f;
        for (int d = 1; d <= 2; d++) begin
            random_frame();
            end_frame();
            check($sformatf("drop%0d_valid", d), 64'(valid), 64'(1));
            check($sformatf("drop%0d_busy", d), 64'(busy), 64'(0));
            check($sformatf("drop%0d_x", d), 64'(ox), 64'(save_x));
            check($sformatf("drop%0d_y", d), 64'(oy), 64'(save_y));
            check($sformatf("drop%0d_found", d), 64'(found), 64'(save_f));
            check($sformatf("drop%0d_cnt", d), 64'(drop), 64'(d));
            $display("drop %0d: valid=%b drop_cnt=%0d", d, valid, drop);
        end
        handshake();

        // Ready and frame end in the same DONE cycle
        random_frame();
        finish_frame("pre_race");
        random_frame();
        de = 1'b0; vs = 1'b0; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("race_valid", 64'(valid), 64'(0));
        check("race_drop", 64'(drop), 64'(3));
        check("race_busy", 64'(busy), 64'(0));
        $display("race: valid=%b busy=%b drop_cnt=%0d", valid, busy, drop);
        random_frame();
        finish_frame("post_race");
        handshake();

        // Reset pulse during DIV
        random_frame();
        end_frame();
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_x", 64'(ox), 64'(0));
        check("mid_rst_y", 64'(oy), 64'(0));
        check("mid_rst_found", 64'(found), 64'(0));
        check("mid_rst_drop", 64'(drop), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) cnt++;
        end
        check("post_rst_quiet", 64'(cnt), 64'(0));
        $display("reset during DIV: quiet cycles with activity=%0d", cnt);
        random_frame();
        finish_frame("post_rst");
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
